// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: timing, request and lamp signals of the phase controller
interface traffic_phase_ctrl_if #(
  parameter int N_PHASES = 4,
  parameter int PW = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
);
  logic [16*N_PHASES-1:0] green_cyc;
  logic [N_PHASES-1:0] demand;
  logic preempt;
  logic [PW-1:0] preempt_phase;
  logic flash;
  logic [N_PHASES-1:0] red;
  logic [N_PHASES-1:0] yellow;
  logic [N_PHASES-1:0] green;
  logic [PW-1:0] active_phase;
  logic phase_start;
  modport master (
    output green_cyc, demand, preempt, preempt_phase, flash,
    input red, yellow, green, active_phase, phase_start
  );
  modport slave (
    input green_cyc, demand, preempt, preempt_phase, flash,
    output red, yellow, green, active_phase, phase_start
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: demand-actuated signal phase sequencer with preemption and flash mode
module traffic_phase_ctrl #(
  parameter int N_PHASES = 4,
  parameter int YELLOW_CYC = 2_000_000,
  parameter int ALLRED_CYC = 1_000_000,
  parameter int MIN_GREEN_CYC = 5_000_000,
  parameter int FLASH_CYC = 25_000_000
) (
  input logic clk,
  input logic rst,
  traffic_phase_ctrl_if.slave bus
);
  localparam int PW = (N_PHASES > 2) ? $clog2(N_PHASES) : 1;
  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, FLASH} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, len_m1;
  logic [PW-1:0] active, nxt, nxt_n, rr_sel, idx;
  logic [N_PHASES-1:0] latch, pending, act_oh, red, yellow, green;
  logic [15:0] glen;
  logic rr_hit, go_green, hold, pre_go, norm_go, fwrap, flash_red, ps;

  function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
    return (v >= (PW+1)'(N_PHASES)) ? PW'(v - (PW+1)'(N_PHASES)) : v[PW-1:0];
  endfunction

  assign act_oh = {{(N_PHASES-1){1'b0}}, 1'b1} << active;
  assign pending = latch & ~act_oh;
  assign glen = bus.green_cyc[{nxt_n, 4'd0} +: 16];

  // round-robin search starting just after the active phase; nearest hit wins
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = active;
    idx = active;
    for (int k = N_PHASES - 1; k >= 1; k--) begin
      idx = wrap({1'b0, active} + (PW+1)'(k));
      if (pending[idx]) begin
        rr_hit = 1'b1;
        rr_sel = idx;
      end
    end
  end

  assign hold = bus.preempt && bus.preempt_phase == active;
  assign pre_go = bus.preempt && !hold && cnt >= 32'(MIN_GREEN_CYC - 1);
  assign norm_go = !hold && cnt >= len_m1 && rr_hit;

  always_comb begin
    state_n = state;
    nxt_n = nxt;
    go_green = 1'b0;
    case (state)
      GREEN: if (pre_go || norm_go) begin
        state_n = YELLOW;
        nxt_n = bus.preempt ? bus.preempt_phase : rr_sel;
      end
      YELLOW: begin
        nxt_n = bus.preempt ? bus.preempt_phase : nxt;
        state_n = (cnt == 32'(YELLOW_CYC - 1)) ? ALLRED : YELLOW;
      end
      ALLRED: begin
        nxt_n = bus.preempt ? bus.preempt_phase : nxt;
        go_green = cnt == 32'(ALLRED_CYC - 1);
        state_n = go_green ? GREEN : ALLRED;
      end
      FLASH: if (!bus.flash) begin
        state_n = ALLRED;
        nxt_n = '0;
      end
    endcase
    if (bus.flash) begin
      state_n = FLASH;
      go_green = 1'b0;
    end
  end

  // the counter restarts on every state change and on each flash half-period
  assign fwrap = state == FLASH && state_n == FLASH && cnt == 32'(FLASH_CYC - 1);
  assign cnt_n = (state_n != state || fwrap) ? '0 : (&cnt ? cnt : cnt + 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALLRED;
      cnt <= '0;
      active <= '0;
      nxt <= '0;
      latch <= '0;
      len_m1 <= '0;
      flash_red <= 1'b1;
      ps <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      nxt <= nxt_n;
      ps <= go_green;
      latch <= (latch | bus.demand) & ~(go_green ? {{(N_PHASES-1){1'b0}}, 1'b1} << nxt_n : '0);
      flash_red <= (state != FLASH) ? 1'b1 : (fwrap ? ~flash_red : flash_red);
      if (go_green) begin
        active <= nxt_n;
        len_m1 <= (glen == 16'd0) ? '0 : 32'(glen - 16'd1);
      end
    end
  end

  always_comb begin
    red = '1;
    yellow = '0;
    green = '0;
    if (state == GREEN) begin
      green = act_oh;
      red = ~act_oh;
    end else if (state == YELLOW) begin
      yellow = act_oh;
      red = ~act_oh;
    end else if (state == FLASH) begin
      red = {N_PHASES{flash_red}};
    end
  end

  assign bus.red = red;
  assign bus.yellow = yellow;
  assign bus.green = green;
  assign bus.active_phase = active;
  assign bus.phase_start = ps;
endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter N_PHASES, default 4, meaning number of signal phases (2..8).
REQ-002 SHALL have parameter YELLOW_CYC, default 2_000_000, meaning yellow interval in clk cycles (>=1).
REQ-003 SHALL have parameter ALLRED_CYC, default 1_000_000, meaning all-red clearance interval in cycles (>=1).
REQ-004 SHALL have parameter MIN_GREEN_CYC, default 5_000_000, meaning minimum green before preemption may terminate it (>=1).
REQ-005 SHALL have parameter FLASH_CYC, default 25_000_000, meaning flash half-period in cycles (>=1).
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port green_cyc  input  16*N_PHASES  per-phase green length in cycles; phase i occupies bits [16*i+15:16*i].
REQ-009 SHALL have port demand  input  N_PHASES  per-phase service request, level or pulse.
REQ-010 SHALL have port preempt  input  1  emergency preemption request.
REQ-011 SHALL have port preempt_phase  input  PW  phase index to serve on preemption; PW = max(1, clog2(N_PHASES)).
REQ-012 SHALL have port flash  input  1  fault/flash mode request.
REQ-013 SHALL have ports red, yellow, green  output  N_PHASES each  lamp drives per phase.
REQ-014 SHALL have port active_phase  output  PW  phase currently green, yellow or last served.
REQ-015 SHALL have port phase_start  output  1  one-cycle pulse on the first green cycle of any phase.

Function
REQ-016 SHALL implement states GREEN, YELLOW, ALLRED, FLASH; one shared 32-bit up-counter, cleared on every state entry.
REQ-017 SHALL drive lamps registered from state: GREEN -> green[active]=1; YELLOW -> yellow[active]=1; every other phase red=1; ALLRED -> all red=1; at most one phase non-red in any cycle.
REQ-018 SHALL sample green_cyc of the entering phase on GREEN entry; value 0 treated as 1; GREEN terminal when counter == len-1.
REQ-019 SHALL keep YELLOW exactly YELLOW_CYC cycles and ALLRED exactly ALLRED_CYC cycles, then YELLOW -> ALLRED -> GREEN(next).
REQ-020 SHALL latch demand[i] into a sticky bit, cleared on the cycle phase i enters GREEN; a demand asserted that same cycle is also cleared.
REQ-021 SHALL select the next phase at GREEN terminal: first phase with a latched demand, searching round-robin from active+1 and excluding active.
REQ-022 SHALL, if no other phase has latched demand at terminal, rest in GREEN with the counter saturated, leaving when any demand latches.
REQ-023 SHALL, on preempt with preempt_phase != active in GREEN, exit to YELLOW once counter >= MIN_GREEN_CYC-1; next phase = preempt_phase.
REQ-024 SHALL, while preempt is high in YELLOW/ALLRED, override the next phase with preempt_phase; SHALL hold GREEN indefinitely while preempt is high and active == preempt_phase.
REQ-025 SHALL, after preempt falls, run the current green to its sampled length measured from GREEN entry, exiting immediately if already past it.
REQ-026 SHALL enter FLASH one cycle after flash is sampled high, from any state; flash has priority over preempt.
REQ-027 SHALL, in FLASH, drive yellow=green=0, all red bits equal and toggling every FLASH_CYC cycles, starting at 1.
REQ-028 SHALL, on flash low in FLASH, go to ALLRED, then GREEN phase 0; demand latches are retained.
REQ-029 SHALL pulse phase_start for exactly one cycle per GREEN entry; no pulse while resting or holding.

Reset
REQ-030 SHALL on rst: state ALLRED, counter 0, active_phase 0, demand latches 0, red all 1, yellow/green 0, phase_start 0.
REQ-031 SHALL after rst release run ALLRED_CYC cycles, then enter GREEN phase 0 unconditionally; rst mid-operation aborts any interval.

Verification (N_PHASES=4, YELLOW_CYC=3, ALLRED_CYC=2, MIN_GREEN_CYC=4, FLASH_CYC=5, all green_cyc=6, rst low at cycle 0)
REQ-032 SHALL cover: no demand -> red=4'hF cycles 0-1, green[0] from cycle 2 held indefinitely, phase_start only at cycle 2.
REQ-033 SHALL cover: demand[2] pulsed at cycle 3 -> green[0] cycles 2-7, yellow[0] 8-10, all red 11-12, green[2] from 13, phase 1 skipped.
REQ-034 SHALL cover: preempt=1, preempt_phase=3 from cycle 3, green_cyc[0]=20 -> yellow[0] at 6-8, all red 9-10, green[3] from 11 while preempt high.
REQ-035 SHALL cover: flash=1 during YELLOW -> next cycle yellow=green=0, red toggles 4'hF/4'h0 every 5 cycles; flash=0 -> 2 all-red cycles, then green[0].
REQ-036 SHALL cover: rst pulsed mid-GREEN of phase 2 with demand[1] latched -> red=4'hF next cycle, latch cleared, green[0] after 2 cycles.
REQ-037 SHALL cover: green_cyc[0]=0 with demand[1] -> green[0] 1 cycle, then yellow; mutual-exclusion assertion checked in all scenarios.
